// File: rtl/latch_write_arbiter_if.sv
// Handshake and latch-bank signals between two requesters, the arbiter and the latch bank.
// The master side drives requests, write data and the latch read-back; the slave is the arbiter.
interface latch_write_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_b;
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             grant_b;
  logic             busy;
  logic             err;

  modport master (
    output req_a, data_a, req_b, data_b, q,
    input  ack_a, ack_b, en, d, grant_b, busy, err
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, q,
    output ack_a, ack_b, en, d, grant_b, busy, err
  );
endinterface

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter driving a shared latch bank with a setup -> enable -> hold write sequence.
// Grant to Ack is EN_CYCLES+1 edges; requesters wait (hold Req) until their Ack pulse.
module latch_write_arbiter #(
  parameter int WIDTH     = 4,
  parameter int EN_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  latch_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_cnt;
  logic             r_ptr_b;
  logic             r_grant_b;
  logic [WIDTH-1:0] r_d;
  logic             r_en;
  logic             r_ack_a;
  logic             r_ack_b;
  logic             r_err;
  logic             w_win_b;
  logic             w_any_req;

  assign w_any_req = bus.req_a | bus.req_b;
  // A lone requester wins regardless of the pointer; the pointer only breaks ties.
  assign w_win_b   = (bus.req_a && bus.req_b) ? r_ptr_b : bus.req_b;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_SETUP;
      S_SETUP: w_next = S_LATCH;
      S_LATCH: if (r_cnt == 8'd0) w_next = S_HOLD;
      S_HOLD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_ptr_b   <= 1'b0;
      r_grant_b <= 1'b0;
      r_d       <= '0;
      r_en      <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any_req) begin
        r_d       <= w_win_b ? bus.data_b : bus.data_a;
        r_grant_b <= w_win_b;
      end
      if (r_state == S_SETUP) begin
        r_cnt <= 8'(EN_CYCLES - 1);
      end else if (r_state == S_LATCH && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      // Outputs are registered from the next state so they line up exactly with the state.
      r_en    <= (w_next == S_LATCH);
      r_ack_a <= (w_next == S_HOLD) && !r_grant_b;
      r_ack_b <= (w_next == S_HOLD) &&  r_grant_b;
      if (r_state == S_HOLD) begin
        r_ptr_b <= ~r_grant_b;
        if (bus.q != r_d) r_err <= 1'b1;
      end
    end
  end

  assign bus.en      = r_en;
  assign bus.d       = r_d;
  assign bus.ack_a   = r_ack_a;
  assign bus.ack_b   = r_ack_b;
  assign bus.grant_b = r_grant_b;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.err     = r_err;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: two instances (EN_CYCLES 1 and 3), each with a behavioural latch
// model on Q, checked per write against a transaction-level arbitration model.
module tb_latch_write_arbiter;

  logic clk;
  logic rst_n [2];
  logic ra [2];
  logic rb [2];
  logic [3:0] da [2];
  logic [3:0] db [2];
  logic stuck [2];
  logic [3:0] lat0;
  logic [3:0] lat1;

  int errors;
  int checks;
  int en_cyc [2];
  bit ptr [2];
  bit merr [2];

  latch_write_arbiter_if #(.WIDTH(4)) if0 ();
  latch_write_arbiter_if #(.WIDTH(4)) if1 ();

  latch_write_arbiter #(.WIDTH(4), .EN_CYCLES(1)) u0 (
    .i_clk   (clk),
    .i_rst_n (rst_n[0]),
    .bus     (if0)
  );

  latch_write_arbiter #(.WIDTH(4), .EN_CYCLES(3)) u1 (
    .i_clk   (clk),
    .i_rst_n (rst_n[1]),
    .bus     (if1)
  );

  assign if0.req_a  = ra[0];
  assign if0.req_b  = rb[0];
  assign if0.data_a = da[0];
  assign if0.data_b = db[0];
  assign if0.q      = stuck[0] ? 4'h0 : lat0;
  assign if1.req_a  = ra[1];
  assign if1.req_b  = rb[1];
  assign if1.data_a = da[1];
  assign if1.data_b = db[1];
  assign if1.q      = stuck[1] ? 4'h0 : lat1;

  // Level-sensitive latch bank models.
  always @(if0.en or if0.d) if (if0.en) lat0 = if0.d;
  always @(if1.en or if1.d) if (if1.en) lat1 = if1.d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int s, output logic en, output logic ack_a, output logic ack_b,
                        output logic gb, output logic busy, output logic err, output logic [3:0] d);
    if (s == 0) begin
      en = if0.en; ack_a = if0.ack_a; ack_b = if0.ack_b; gb = if0.grant_b;
      busy = if0.busy; err = if0.err; d = if0.d;
    end else begin
      en = if1.en; ack_a = if1.ack_a; ack_b = if1.ack_b; gb = if1.grant_b;
      busy = if1.busy; err = if1.err; d = if1.d;
    end
  endtask

  // Called #1 after an edge with the DUT idle and requests already set up.
  task automatic do_write(input int s, input bit drop, input bit perturb);
    bit w;
    logic [3:0] ed;
    int enc;
    int lat;
    bit got;
    logic en, aa, ab, gb, busy, err;
    logic [3:0] d;
    w   = (ra[s] && rb[s]) ? ptr[s] : rb[s];
    ed  = w ? db[s] : da[s];
    enc = 0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      sample(s, en, aa, ab, gb, busy, err, d);
      chk("busy_in_write", busy, 1);
      chk("d_stable", d, ed);
      chk("ack_overlap", aa & ab, 0);
      if (en) enc++;
      if (aa | ab) begin
        got = 1;
        lat = i;
        chk("ack_a", aa, !w);
        chk("ack_b", ab, w);
        chk("grant_b", gb, w);
        chk("en_low_hold", en, 0);
      end else if (perturb) begin
        da[s] = 4'($urandom);
        db[s] = 4'($urandom);
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    chk("ack_latency", lat, en_cyc[s] + 1);
    chk("en_width", enc, en_cyc[s]);
    @(posedge clk); #1;
    if (drop) begin
      if (w) rb[s] = 1'b0;
      else   ra[s] = 1'b0;
    end
    ptr[s]  = !w;
    merr[s] = merr[s] | ((stuck[s] ? 4'h0 : ed) != ed);
    sample(s, en, aa, ab, gb, busy, err, d);
    chk("err_after", err, merr[s]);
    chk("busy_idle", busy, 0);
    chk("ack_gone", aa | ab, 0);
  endtask

  initial begin
    logic en, aa, ab, gb, busy, err;
    logic [3:0] d;
    bit seen;
    errors = 0;
    checks = 0;
    en_cyc[0] = 1;
    en_cyc[1] = 3;
    lat0 = 4'h0;
    lat1 = 4'h0;
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; ra[s] = 1'b0; rb[s] = 1'b0;
      da[s] = 4'h0; db[s] = 4'h0; stuck[s] = 1'b0;
      ptr[s] = 1'b0; merr[s] = 1'b0;
    end

    // Reset held with a pending request.
    ra[0] = 1'b1;
    da[0] = 4'hA;
    repeat (3) @(posedge clk);
    #1;
    sample(0, en, aa, ab, gb, busy, err, d);
    chk("rst_en", en, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ack", aa | ab, 0);
    chk("rst_grant_b", gb, 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Single write from A.
    do_write(0, 1, 0);

    // Contention: both held, fixed data.
    ra[0] = 1'b1; rb[0] = 1'b1; da[0] = 4'h3; db[0] = 4'hC;
    repeat (4) do_write(0, 0, 0);
    ra[0] = 1'b0; rb[0] = 1'b0;

    // Randomized traffic; a loser keeps its request up until served.
    for (int k = 0; k < 24; k++) begin
      if (!ra[0] && $urandom_range(0, 1) == 1) ra[0] = 1'b1;
      if (!rb[0] && $urandom_range(0, 1) == 1) rb[0] = 1'b1;
      if (!ra[0] && !rb[0]) ra[0] = 1'b1;
      da[0] = 4'($urandom);
      db[0] = 4'($urandom);
      do_write(0, 1, 1);
    end

    // Longer enable window with data churn during the write.
    ra[1] = 1'b1; da[1] = 4'($urandom);
    do_write(1, 1, 1);
    ra[1] = 1'b1; rb[1] = 1'b1; da[1] = 4'($urandom); db[1] = 4'($urandom);
    do_write(1, 1, 1);
    do_write(1, 1, 1);

    // Stuck read-back sets the sticky error.
    ra[0] = 1'b1; rb[0] = 1'b0; da[0] = 4'h5; stuck[0] = 1'b1;
    do_write(0, 1, 0);
    stuck[0] = 1'b0;
    rb[0] = 1'b1; db[0] = 4'($urandom);
    do_write(0, 1, 0);

    // Reset while En is high, then B is regranted from idle.
    ra[0] = 1'b0; rb[0] = 1'b1; db[0] = 4'h9;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      sample(0, en, aa, ab, gb, busy, err, d);
      if (en) seen = 1;
    end
    chk("midrst_en_seen", seen, 1);
    rst_n[0] = 1'b0;
    #1;
    sample(0, en, aa, ab, gb, busy, err, d);
    chk("midrst_en", en, 0);
    chk("midrst_ack", aa | ab, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    @(posedge clk); #1;
    sample(0, en, aa, ab, gb, busy, err, d);
    chk("midrst_ack_held", aa | ab, 0);
    rst_n[0] = 1'b1;
    ptr[0]  = 1'b0;
    merr[0] = 1'b0;
    db[0]   = 4'h6;
    do_write(0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
